// File: rtl/alu_seq_pkg.sv
// Shared opcode and state encodings for the sequential ALU and its multiplier.
package alu_seq_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_AND     = 3'b010,
        OP_OR      = 3'b011,
        OP_XOR     = 3'b100,
        OP_NOT     = 3'b101,
        OP_MUL     = 3'b110,
        OP_ILLEGAL = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/consume bus of the sequential ALU: operand handshake in, result handshake out.
interface alu_seq_if #(
    parameter int WIDTH = 16
) ();

    // Both handshakes: a transfer happens on a rising clk edge where valid && ready;
    // the producer holds its payload stable while valid is high and ready is low.
    logic                            in_valid;
    logic                            in_ready;
    logic [alu_seq_pkg::OPC_W-1:0]   opcode;
    logic [WIDTH-1:0]                input_a;
    logic [WIDTH-1:0]                input_b;
    logic                            out_valid;
    logic                            out_ready;
    logic [WIDTH-1:0]                result;
    logic [WIDTH-1:0]                result_hi;
    logic                            flag_zero;
    logic                            flag_carry;
    logic                            flag_ovf;
    logic                            flag_err;

    modport master (
        output in_valid, opcode, input_a, input_b, out_ready,
        input  in_ready, out_valid, result, result_hi,
               flag_zero, flag_carry, flag_ovf, flag_err
    );

    modport slave (
        input  in_valid, opcode, input_a, input_b, out_ready,
        output in_ready, out_valid, result, result_hi,
               flag_zero, flag_carry, flag_ovf, flag_err
    );

endinterface

// File: rtl/alu_shift_add_mul.sv
// Unsigned shift-add multiplier: one partial product per clock, WIDTH clocks per product.
module alu_shift_add_mul #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CNT_W'(1));

    // The product port carries the accumulator including this edge's partial
    // product, so the final value can be captured on the same edge as done.
    always_comb begin
        acc_next = acc_q;
        if (mplier_q[0]) begin
            acc_next = acc_q + mcand_q;
        end
    end

    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, op_a};
            acc_q    <= '0;
            mplier_q <= op_b;
            cnt_q    <= CNT_W'(WIDTH);
        end else if (busy) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops, multi-cycle unsigned multiply,
// registered result and status flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_seq_if.slave bus,
    output state_e dbg_state
);

    state_e             state_q;
    state_e             state_d;
    opcode_e            op;
    logic               accept;
    logic               is_mul;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_o;
    logic               alu_e;

    assign op        = opcode_e'(bus.opcode);
    assign is_mul    = (op == OP_MUL);
    assign accept    = bus.in_valid && bus.in_ready;
    assign dbg_state = state_q;

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst_n),
        .start   (accept && is_mul),
        .op_a    (bus.input_a),
        .op_b    (bus.input_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An idle multiplier while in MUL_BUSY can only follow a lost start; fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = is_mul ? MUL_BUSY : DONE;
            end
            MUL_BUSY: begin
                if (mul_done)       state_d = DONE;
                else if (!mul_busy) state_d = IDLE;
            end
            DONE: begin
                if (bus.out_ready) state_d = accept ? (is_mul ? MUL_BUSY : DONE) : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: bus.in_ready = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Carry/borrow come from the extra MSB of the WIDTH+1 bit sum/difference.
    always_comb begin
        sum     = {1'b0, bus.input_a} + {1'b0, bus.input_b};
        diff    = {1'b0, bus.input_a} - {1'b0, bus.input_b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        alu_e   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_o   = (bus.input_a[WIDTH-1] == bus.input_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.input_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_o   = (bus.input_a[WIDTH-1] != bus.input_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.input_a[WIDTH-1]);
            end
            OP_AND:     alu_res = bus.input_a & bus.input_b;
            OP_OR:      alu_res = bus.input_a | bus.input_b;
            OP_XOR:     alu_res = bus.input_a ^ bus.input_b;
            OP_NOT:     alu_res = ~bus.input_a;
            OP_ILLEGAL: alu_e   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            bus.result     <= '0;
            bus.result_hi  <= '0;
            bus.flag_zero  <= 1'b0;
            bus.flag_carry <= 1'b0;
            bus.flag_ovf   <= 1'b0;
            bus.flag_err   <= 1'b0;
        end else if (accept && !is_mul) begin
            bus.result     <= alu_res;
            bus.result_hi  <= '0;
            bus.flag_zero  <= (alu_res == '0);
            bus.flag_carry <= alu_c;
            bus.flag_ovf   <= alu_o;
            bus.flag_err   <= alu_e;
        end else if ((state_q == MUL_BUSY) && mul_done) begin
            bus.result     <= mul_product[WIDTH-1:0];
            bus.result_hi  <= mul_product[2*WIDTH-1:WIDTH];
            bus.flag_zero  <= (mul_product == '0);
            bus.flag_carry <= 1'b0;
            bus.flag_ovf   <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            bus.flag_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: arithmetic model with an expected-result queue plus literal checks.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W  = 16;
    localparam int EW = 2 * W + 4;

    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    state_e dbg_state;
    int     n_checks = 0;
    int     n_fail = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Expected {result_hi, result, zero, carry, ovf, err} from plain integer arithmetic.
    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int               ua, ub, u, sa, sb, s;
        longint unsigned  p;
        logic [W-1:0]     res, hi;
        logic             z, c, o, e;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        res = '0; hi = '0; c = 1'b0; o = 1'b0; e = 1'b0;
        p = 0;
        case (op)
            3'd0: begin
                u = ua + ub; s = sa + sb;
                res = W'(u); c = (u >= (1 << W));
                o = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            3'd1: begin
                u = ua - ub; s = sa - sb;
                res = W'(u); c = (ua < ub);
                o = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = ~a;
            3'd6: begin
                p = longint'(ua) * longint'(ub);
                res = W'(p); hi = W'(p >> W); o = (hi != 0);
            end
            default: e = 1'b1;
        endcase
        z = (op == 3'd6) ? (p == 0) : (res == 0);
        return {hi, res, z, c, o, e};
    endfunction

    function automatic logic [EW-1:0] dut_pack();
        return {bus.result_hi, bus.result, bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_err};
    endfunction

    // Scoreboard: every cycle a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n && bus.out_valid === 1'b1) begin
            check("queue_has_entry", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                check("model_vs_dut", 64'(dut_pack()), 64'(exp_q[0]));
                if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit keep, output int waited);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.input_a  = a;
        bus.input_b  = b;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        check("issue_in_ready", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready === 1'b1) exp_q.push_back(model(op, a, b));
        tick();
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
        int w;
        issue(3'd6, a, b, 1'b0, w);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            check("mul_busy_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
            cyc++;
        end
        check("mul_latency", 64'(cyc), 64'd16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, cyc;
        logic [EW-1:0] snap;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.input_a   = '0;
        bus.input_b   = '0;
        bus.out_ready = 1'b1;

        rst_n = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_outputs", 64'(dut_pack()), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));

        check("model_add_pin", 64'(model(3'd0, 16'hFFFF, 16'h0001)), {28'd0, 16'h0000, 16'h0000, 4'b1100});
        check("model_sub_pin", 64'(model(3'd1, 16'h8000, 16'h0001)), {28'd0, 16'h0000, 16'h7FFF, 4'b0010});
        check("model_mul_pin", 64'(model(3'd6, 16'hFFFF, 16'hFFFF)), {28'd0, 16'hFFFE, 16'h0001, 4'b0010});
        check("model_ill_pin", 64'(model(3'd7, 16'h1234, 16'h5678)), {28'd0, 16'h0000, 16'h0000, 4'b1001});

        issue(3'd0, 16'hFFFF, 16'h0001, 1'b0, w);
        check("add_valid", 64'(bus.out_valid), 64'd1);
        check("add_result", 64'(bus.result), 64'h0000);
        check("add_flags_zcoe", 64'({bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_err}), 64'b1100);
        tick();

        issue(3'd1, 16'h8000, 16'h0001, 1'b0, w);
        check("sub1_result", 64'(bus.result), 64'h7FFF);
        check("sub1_ovf", 64'(bus.flag_ovf), 64'd1);
        check("sub1_carry", 64'(bus.flag_carry), 64'd0);
        tick();
        issue(3'd1, 16'h0003, 16'h0005, 1'b0, w);
        check("sub2_result", 64'(bus.result), 64'hFFFE);
        check("sub2_carry", 64'(bus.flag_carry), 64'd1);
        tick();

        issue(3'd0, 16'h7FFF, 16'h0001, 1'b0, w);
        check("add_ovf", 64'(bus.flag_ovf), 64'd1);
        tick();

        run_mul(16'h1234, 16'h0100, cyc);
        check("mul1_result", 64'(bus.result), 64'h3400);
        check("mul1_hi", 64'(bus.result_hi), 64'h0012);
        check("mul1_ovf", 64'(bus.flag_ovf), 64'd1);
        tick();
        run_mul(16'hFFFF, 16'hFFFF, cyc);
        check("mul2_result", 64'(bus.result), 64'h0001);
        check("mul2_hi", 64'(bus.result_hi), 64'hFFFE);
        tick();
        run_mul(16'h0000, 16'hABCD, cyc);
        check("mul0_zero", 64'(bus.flag_zero), 64'd1);
        tick();

        issue(3'd2, 16'hF0F0, 16'h0FF0, 1'b1, w);
        check("and_result", 64'(bus.result), 64'h00F0);
        issue(3'd3, 16'hF0F0, 16'h0FF0, 1'b1, w);
        check("b2b_or_wait", 64'(w), 64'd0);
        check("or_result", 64'(bus.result), 64'hFFF0);
        issue(3'd4, 16'hF0F0, 16'h0FF0, 1'b1, w);
        check("b2b_xor_wait", 64'(w), 64'd0);
        issue(3'd5, 16'h00FF, 16'h1234, 1'b0, w);
        check("b2b_not_wait", 64'(w), 64'd0);
        check("not_result", 64'(bus.result), 64'hFF00);
        tick();

        bus.out_ready = 1'b0;
        issue(3'd4, 16'h1234, 16'h00FF, 1'b0, w);
        snap = dut_pack();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_result", 64'(bus.result), 64'h12CB);
            check("bp_stable", 64'(dut_pack()), 64'(snap));
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_drain_valid", 64'(bus.out_valid), 64'd0);
        check("bp_drain_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;

        issue(3'd6, 16'h00FF, 16'h0101, 1'b0, w);
        repeat (6) tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        rst_n = 1'b0;
        check("midrst_outputs", 64'(dut_pack()), 64'd0);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid !== 1'b0) cyc++;
            tick();
        end
        check("midrst_no_stale_result", 64'(cyc), 64'd0);

        issue(3'd7, 16'hABCD, 16'h1234, 1'b0, w);
        check("ill_result", 64'(bus.result), 64'h0000);
        check("ill_hi", 64'(bus.result_hi), 64'h0000);
        check("ill_flags_zcoe", 64'({bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_err}), 64'b1001);
        tick();

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
